// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, requester
// IDs and the legal memory-latency range.
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      REQ_CORE = 1'b0,
      REQ_LDR  = 1'b1
   } req_id_t;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;

   // Wide enough to hold MEM_LAT_MAX-1.
   localparam int CNT_W = 2;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
// Ports:
//   req_core, req_ldr : request bits
//   last              : requester granted most recently
//   winner            : chosen requester (meaningful only when valid)
//   valid             : at least one request present
module rr_pick2
   import riscv_mem_pkg::*;
(
   input  logic    req_core,
   input  logic    req_ldr,
   input  req_id_t last,
   output req_id_t winner,
   output logic    valid
);

   always_comb begin
      valid  = req_core | req_ldr;
      winner = REQ_CORE;
      if (req_core && req_ldr) begin
         winner = (last == REQ_CORE) ? REQ_LDR : REQ_CORE;
      end else if (req_ldr) begin
         winner = REQ_LDR;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core load/store path and
// the program loader. Round-robin arbitration in IDLE, one-cycle ISSUE,
// read-wait down-counter, registered read data with a one-cycle valid pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; arbitrate and latch winner's request
// ISSUE | one cycle: gnt to owner, memory strobe from latched request
// WAIT  | read in flight; capture mem_rdata when the counter hits 0
//
// Ports:
//   clk, rst (async, active-low)
//   core_* / ldr_*  : req/we/addr/wdata in; gnt/rvalid/rdata out
//   core_stall      : core waiting for its access to complete
//   mem_*           : strobes, address and write data to memory; mem_rdata in
//   busy            : FSM not in IDLE
module dmem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int ADDR_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              ldr_req,
   input  logic              core_we,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [WIDTH-1:0]  core_wdata,
   input  logic [WIDTH-1:0]  ldr_wdata,
   output logic              core_gnt,
   output logic              ldr_gnt,
   output logic              core_rvalid,
   output logic              ldr_rvalid,
   output logic [WIDTH-1:0]  core_rdata,
   output logic [WIDTH-1:0]  ldr_rdata,
   output logic              core_stall,
   output logic              mem_read_en,
   output logic              mem_write_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic              busy
);

   if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
      $error("dmem_arbiter: MEM_LAT must be within 1..4");
   end

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   state_t            state_q, state_d;
   req_id_t           last_q, owner_q, pick;
   logic              pick_valid;
   logic [CNT_W-1:0]  cnt_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WIDTH-1:0]  wdata_q;
   logic [WIDTH-1:0]  core_rdata_q, ldr_rdata_q;
   logic              core_rvalid_q, ldr_rvalid_q;
   logic              issue, rd_done;

   rr_pick2 u_pick (
      .req_core (core_req),
      .req_ldr  (ldr_req),
      .last     (last_q),
      .winner   (pick),
      .valid    (pick_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rd_done      = 1'b0;
      issue        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            issue   = 1'b1;
            state_d = we_q ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               rd_done = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q        <= REQ_LDR;
         owner_q       <= REQ_CORE;
         cnt_q         <= '0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         core_rdata_q  <= '0;
         ldr_rdata_q   <= '0;
         core_rvalid_q <= 1'b0;
         ldr_rvalid_q  <= 1'b0;
      end else begin
         core_rvalid_q <= 1'b0;
         ldr_rvalid_q  <= 1'b0;

         // Memory side is driven only from these latches, never live inputs.
         if (state_q == ST_IDLE && pick_valid) begin
            owner_q <= pick;
            if (pick == REQ_CORE) begin
               we_q    <= core_we;
               addr_q  <= core_addr;
               wdata_q <= core_wdata;
            end else begin
               we_q    <= ldr_we;
               addr_q  <= ldr_addr;
               wdata_q <= ldr_wdata;
            end
         end

         if (issue) begin
            last_q <= owner_q;
            if (!we_q) cnt_q <= CNT_LOAD;
         end else if (state_q == ST_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end

         if (rd_done) begin
            if (owner_q == REQ_CORE) begin
               core_rdata_q  <= mem_rdata;
               core_rvalid_q <= 1'b1;
            end else begin
               ldr_rdata_q   <= mem_rdata;
               ldr_rvalid_q  <= 1'b1;
            end
         end
      end
   end

   assign core_gnt     = issue && (owner_q == REQ_CORE);
   assign ldr_gnt      = issue && (owner_q == REQ_LDR);
   assign mem_read_en  = issue && !we_q;
   assign mem_write_en = issue && we_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign core_rdata   = core_rdata_q;
   assign ldr_rdata    = ldr_rdata_q;
   assign core_rvalid  = core_rvalid_q;
   assign ldr_rvalid   = ldr_rvalid_q;
   assign busy         = (state_q != ST_IDLE);

   // A core write is done at its grant; a core read is done at its rvalid.
   assign core_stall   = core_req && !((core_gnt && we_q) || core_rvalid_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with MEM_LAT = 3. Drivers issue requests;
// a negedge monitor predicts arbitration, strobes, busy, rvalid timing and
// read data from a reference memory and compares against the DUT.
module tb_dmem_arbiter;
   import riscv_mem_pkg::*;

   localparam int W   = 32;
   localparam int AW  = 32;
   localparam int LAT = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          core_req = 1'b0, ldr_req = 1'b0;
   logic          core_we = 1'b0, ldr_we = 1'b0;
   logic [AW-1:0] core_addr = '0, ldr_addr = '0;
   logic [W-1:0]  core_wdata = '0, ldr_wdata = '0;
   logic          core_gnt, ldr_gnt, core_rvalid, ldr_rvalid, core_stall;
   logic          mem_read_en, mem_write_en, busy;
   logic [W-1:0]  core_rdata, ldr_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   int            n_checks = 0;
   int            n_fail   = 0;
   int unsigned   cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_arbiter #(.WIDTH(W), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .core_req     (core_req),
      .ldr_req      (ldr_req),
      .core_we      (core_we),
      .ldr_we       (ldr_we),
      .core_addr    (core_addr),
      .ldr_addr     (ldr_addr),
      .core_wdata   (core_wdata),
      .ldr_wdata    (ldr_wdata),
      .core_gnt     (core_gnt),
      .ldr_gnt      (ldr_gnt),
      .core_rvalid  (core_rvalid),
      .ldr_rvalid   (ldr_rvalid),
      .core_rdata   (core_rdata),
      .ldr_rdata    (ldr_rdata),
      .core_stall   (core_stall),
      .mem_read_en  (mem_read_en),
      .mem_write_en (mem_write_en),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .busy         (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_val(input int i);
      return 32'hA5A5_0000 ^ (32'(i) * 32'h01F3_0B07);
   endfunction

   // Memory device: data is correct only in the exact sampling cycle, so an
   // early or late capture picks up the inverted value.
   logic [W-1:0] dev_mem [16];
   bit           dev_init = 1'b0;
   logic [3:0]   rd_idx = '0;
   int unsigned  rd_cyc = 0;

   always @(posedge clk) begin
      if (!dev_init) begin
         for (int i = 0; i < 16; i++) dev_mem[i] <= init_val(i);
         dev_init <= 1'b1;
      end
      if (mem_write_en) dev_mem[mem_addr[5:2]] <= mem_wdata;
      if (mem_read_en) begin
         rd_idx <= mem_addr[5:2];
         rd_cyc <= cyc;
      end
   end

   assign mem_rdata = (cyc == rd_cyc + LAT) ? dev_mem[rd_idx] : ~dev_mem[rd_idx];

   // Reference model and scoreboard.
   typedef struct {
      logic [31:0] data;
      int unsigned at;
   } exp_t;

   exp_t        core_q[$], ldr_q[$];
   req_id_t     gnt_log[$];
   logic [31:0] ref_mem [16];
   bit          ref_init = 1'b0;
   logic [31:0] core_hold = '0, ldr_hold = '0;
   req_id_t     m_last = REQ_LDR;
   bit          pc = 1'b0, pl = 1'b0;
   int unsigned next_ok = 0, busy_end = 0;
   bit          busy_valid = 1'b0;
   bit          m_exp_rd, m_exp_wr, m_core_wgnt, m_core_rv, m_ldr_rv;
   req_id_t     m_w;
   logic        m_we;
   logic [31:0] m_a, m_d;
   exp_t        m_e;

   always @(negedge clk) begin
      if (!ref_init) begin
         for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
         ref_init = 1'b1;
      end
      if (!rst) begin
         core_q.delete();
         ldr_q.delete();
         core_hold  = '0;
         ldr_hold   = '0;
         m_last     = REQ_LDR;
         next_ok    = 0;
         busy_valid = 1'b0;
      end else begin
         m_exp_rd    = 1'b0;
         m_exp_wr    = 1'b0;
         m_core_wgnt = 1'b0;
         if (core_gnt || ldr_gnt) begin
            check("gnt_onehot", 32'(core_gnt & ldr_gnt), 32'd0);
            check("gnt_had_req", 32'(pc | pl), 32'd1);
            check("gnt_spacing", 32'(cyc >= next_ok), 32'd1);
            if (pc && pl) m_w = (m_last == REQ_CORE) ? REQ_LDR : REQ_CORE;
            else          m_w = pc ? REQ_CORE : REQ_LDR;
            check("gnt_winner", 32'(ldr_gnt), 32'(m_w == REQ_LDR));
            if (m_w == REQ_CORE) begin
               m_we = core_we; m_a = core_addr; m_d = core_wdata;
            end else begin
               m_we = ldr_we;  m_a = ldr_addr;  m_d = ldr_wdata;
            end
            check("mem_addr", mem_addr, m_a);
            m_exp_wr = m_we;
            m_exp_rd = !m_we;
            if (m_we) begin
               check("mem_wdata", mem_wdata, m_d);
               ref_mem[m_a[5:2]] = m_d;
               next_ok  = cyc + 2;
               busy_end = cyc;
            end else begin
               m_e.data = ref_mem[m_a[5:2]];
               m_e.at   = cyc + 1 + LAT;
               if (m_w == REQ_CORE) core_q.push_back(m_e);
               else                 ldr_q.push_back(m_e);
               next_ok  = cyc + 2 + LAT;
               busy_end = cyc + LAT;
            end
            busy_valid  = 1'b1;
            m_last      = m_w;
            gnt_log.push_back(m_w);
            m_core_wgnt = (m_w == REQ_CORE) && m_we;
         end
         check("mem_read_en", 32'(mem_read_en), 32'(m_exp_rd));
         check("mem_write_en", 32'(mem_write_en), 32'(m_exp_wr));
         check("busy", 32'(busy), 32'(busy_valid && cyc <= busy_end));

         m_core_rv = (core_q.size() > 0) && (core_q[0].at == cyc);
         check("core_rvalid", 32'(core_rvalid), 32'(m_core_rv));
         if (m_core_rv) begin
            core_hold = core_q[0].data;
            void'(core_q.pop_front());
         end
         check("core_rdata", core_rdata, core_hold);

         m_ldr_rv = (ldr_q.size() > 0) && (ldr_q[0].at == cyc);
         check("ldr_rvalid", 32'(ldr_rvalid), 32'(m_ldr_rv));
         if (m_ldr_rv) begin
            ldr_hold = ldr_q[0].data;
            void'(ldr_q.pop_front());
         end
         check("ldr_rdata", ldr_rdata, ldr_hold);

         check("core_stall", 32'(core_stall), 32'(core_req && !(m_core_wgnt || m_core_rv)));
      end
      pc = core_req;
      pl = ldr_req;
   end

   task automatic set_req(input req_id_t who, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic r);
      if (who == REQ_CORE) begin
         core_we = we; core_addr = a; core_wdata = d; core_req = r;
      end else begin
         ldr_we = we;  ldr_addr = a;  ldr_wdata = d;  ldr_req = r;
      end
   endtask

   task automatic wait_gnt(output req_id_t who, output bit ok);
      int n;
      n   = 0;
      ok  = 1'b0;
      who = REQ_CORE;
      while (!ok && n < 60) begin
         @(negedge clk);
         n++;
         if (core_gnt || ldr_gnt) begin
            ok  = 1'b1;
            who = ldr_gnt ? REQ_LDR : REQ_CORE;
         end
      end
      check("gnt_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_ldr_rv();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ldr_rvalid && n < 60);
      check("ldr_rvalid_timeout", 32'(ldr_rvalid), 32'd1);
   endtask

   task automatic drive(input req_id_t who, input int n, input bit rnd);
      logic        we;
      logic [31:0] a, d;
      int          w, k;
      bit          got;
      for (int i = 0; i < n; i++) begin
         we = 1'b0;
         if (rnd) begin
            k = $urandom_range(0, 3);
            if (k > 0) begin
               repeat (k) @(posedge clk);
               #1;
            end
            we = 1'($urandom_range(0, 1));
         end
         a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         d = $urandom;
         set_req(who, we, a, d, 1'b1);
         w   = 0;
         got = 1'b0;
         while (!got && w < 100) begin
            @(negedge clk);
            w++;
            got = (who == REQ_CORE) ? core_gnt : ldr_gnt;
         end
         check((who == REQ_CORE) ? "core_drv_timeout" : "ldr_drv_timeout", 32'(got), 32'd1);
         @(posedge clk);
         #1;
         set_req(who, we, a, d, 1'b0);
      end
   endtask

   req_id_t who;
   bit      ok;

   initial begin
      // Reset held with both requesting.
      rst = 1'b0;
      set_req(REQ_CORE, 1'b0, 32'h08, 32'h0, 1'b1);
      set_req(REQ_LDR,  1'b0, 32'h10, 32'h0, 1'b1);
      repeat (3) @(negedge clk);
      check("rst_outputs", {25'd0, core_gnt, ldr_gnt, core_rvalid, ldr_rvalid,
                            mem_read_en, mem_write_en, busy}, 32'd0);
      check("rst_rdata", core_rdata | ldr_rdata, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      wait_gnt(who, ok);
      check("first_gnt_core", 32'(who), 32'(REQ_CORE));
      @(posedge clk);
      #1 core_req = 1'b0;
      wait_gnt(who, ok);
      check("second_gnt_ldr", 32'(who), 32'(REQ_LDR));
      @(posedge clk);
      #1 ldr_req = 1'b0;
      repeat (8) @(posedge clk);

      // Directed core write then read of 0x40.
      #1 set_req(REQ_CORE, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1);
      @(negedge clk);
      check("wr_t_gnt", 32'(core_gnt), 32'd0);
      @(negedge clk);
      check("wr_gnt", 32'(core_gnt), 32'd1);
      check("wr_strobe", 32'(mem_write_en), 32'd1);
      check("wr_addr", mem_addr, 32'h40);
      @(posedge clk);
      #1 core_req = 1'b0;
      @(negedge clk);
      check("wr_busy_t2", 32'(busy), 32'd0);
      @(posedge clk);
      #1 set_req(REQ_CORE, 1'b0, 32'h40, 32'h0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("rd_gnt", 32'(core_gnt), 32'd1);
      check("rd_strobe", 32'(mem_read_en), 32'd1);
      @(posedge clk);
      #1 core_req = 1'b0;
      repeat (3) @(negedge clk);
      check("rd_rvalid_early", 32'(core_rvalid), 32'd0);
      @(negedge clk);
      check("rd_rvalid_t5", 32'(core_rvalid), 32'd1);
      check("rd_data", core_rdata, 32'hDEADBEEF);
      check("rd_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
      repeat (4) @(posedge clk);

      // Reset while a loader read is in WAIT.
      #1 set_req(REQ_LDR, 1'b0, 32'h24, 32'h0, 1'b1);
      wait_gnt(who, ok);
      check("rw_gnt_ldr", 32'(who), 32'(REQ_LDR));
      @(posedge clk);
      #1 ldr_req = 1'b0;
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rw_busy_rst", 32'(busy), 32'd0);
      check("rw_ldr_rdata_rst", ldr_rdata, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (LAT + 4) @(negedge clk);
      check("rw_no_rvalid", 32'(ldr_rvalid | core_rvalid), 32'd0);
      check("rw_ldr_rdata", ldr_rdata, 32'd0);
      check("rw_idle", 32'(busy), 32'd0);
      @(posedge clk);
      #1 set_req(REQ_LDR, 1'b0, 32'h40, 32'h0, 1'b1);
      wait_gnt(who, ok);
      @(posedge clk);
      #1 ldr_req = 1'b0;
      wait_ldr_rv();
      check("rw_new_read", ldr_rdata, 32'hDEADBEEF);
      repeat (4) @(posedge clk);

      // Both hold reads continuously: 8 grants must alternate.
      #1 gnt_log.delete();
      fork
         drive(REQ_CORE, 4, 1'b0);
         drive(REQ_LDR,  4, 1'b0);
      join
      repeat (LAT + 4) @(posedge clk);
      check("alt_count", 32'(gnt_log.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < gnt_log.size())
            check("alt_order", 32'(gnt_log[i]), (i % 2 == 0) ? 32'(REQ_CORE) : 32'(REQ_LDR));
      end

      // Randomized mixed traffic.
      #1;
      fork
         drive(REQ_CORE, 30, 1'b1);
         drive(REQ_LDR,  30, 1'b1);
      join
      repeat (LAT + 8) @(negedge clk);
      check("drain_core_q", 32'(core_q.size()), 32'd0);
      check("drain_ldr_q", 32'(ldr_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
